sram_input_loader: RTL and testbench

- Upstream fill stage for the 128 x 64-bit input SRAM.
- Accepts a 16-bit element stream with a valid/ready handshake and packs 4 elements into one 64-bit line.
- Writes each line into the SRAM through its single port (active-low chip enable, active-high write enable) at consecutive, wrapping addresses.
- Signals frame completion to the controller.

---
 rtl/sram_input_loader_if.sv | 13 +
 rtl/sram_input_loader.sv | 126 ++++++++++++
 tb/tb_sram_input_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_input_loader_if.sv
// Valid/ready element stream feeding the input SRAM loader.
// The source drives valid/data/last and the loader answers with ready.
interface sram_input_loader_if #(
    parameter int LANE_WIDTH = 16
) ();
    logic                  valid;
    logic [LANE_WIDTH-1:0] data;
    logic                  last;
    logic                  ready;

    modport master (output valid, output data, output last, input  ready);
    modport slave  (input  valid, input  data, input  last, output ready);
endinterface

// File: rtl/sram_input_loader.sv
// Packs LANES stream elements into one SRAM line and writes the lines of a frame
// to consecutive, wrapping addresses, then pulses done for the controller.
module sram_input_loader #(
    parameter int LANE_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    input  logic [ADDR_WIDTH:0]         num_words,
    sram_input_loader_if.slave          s,
    output logic                        sram_cen_n,
    output logic                        sram_wen,
    output logic [ADDR_WIDTH-1:0]       sram_addr,
    output logic [LANE_WIDTH*LANES-1:0] sram_data_in,
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_WIDTH:0]         words_written
);

    localparam int DATA_W     = LANE_WIDTH * LANES;
    localparam int CNT_W      = ADDR_WIDTH + 1;
    localparam int LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [CNT_W-1:0]        remaining;
    logic [LANE_IDX_W-1:0]   lane;
    logic [DATA_W-1:0]       pack;

    logic                    accept;
    logic                    line_done;
    logic                    frame_end;
    logic [DATA_W-1:0]       line_next;
    logic [CNT_W-1:0]        frame_len;
    logic [ADDR_WIDTH-1:0]   addr_inc;

    // NOTE: line_next gets its default before the partial overwrite; without it
    // the unwritten lanes would hold their old value and infer a latch.
    always_comb begin
        line_next = pack;
        line_next[lane*LANE_WIDTH +: LANE_WIDTH] = s.data;
    end

    assign accept    = (state == FILL) && s.valid && s.ready;
    assign line_done = accept && ((lane == LANE_IDX_W'(LANES - 1)) || s.last);
    // A frame stops at whichever comes first: its last budgeted line or s_last.
    assign frame_end = line_done && (s.last || (remaining == CNT_W'(1)));
    assign frame_len = (num_words > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_words;
    assign addr_inc  = (addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr + ADDR_WIDTH'(1);

    // NOTE: all state updates are non-blocking so every register samples the
    // pre-edge values; the strobes default inactive and are overridden below.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            lane          <= '0;
            pack          <= '0;
            s.ready       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
            sram_cen_n    <= 1'b1;
            sram_wen      <= 1'b0;
            sram_addr     <= '0;
            sram_data_in  <= '0;
        end else begin
            sram_cen_n <= 1'b1;
            sram_wen   <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_words == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr          <= base_addr;
                            remaining     <= frame_len;
                            lane          <= '0;
                            pack          <= '0;
                            words_written <= '0;
                            s.ready       <= 1'b1;
                            busy          <= 1'b1;
                            state         <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (line_done) begin
                        sram_cen_n    <= 1'b0;
                        sram_wen      <= 1'b1;
                        sram_addr     <= addr;
                        sram_data_in  <= line_next;
                        words_written <= words_written + CNT_W'(1);
                        addr          <= addr_inc;
                        remaining     <= remaining - CNT_W'(1);
                        lane          <= '0;
                        pack          <= '0;
                        if (frame_end) begin
                            s.ready <= 1'b0;
                            state   <= FLUSH;
                        end
                    end else if (accept) begin
                        pack <= line_next;
                        lane <= lane + LANE_IDX_W'(1);
                    end
                end
                FLUSH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_input_loader.sv
// Randomized frames against a queue-based model of the expected SRAM line writes,
// plus the directed zero-length, wrap, gap and mid-frame reset cases.
module tb_sram_input_loader;

    localparam int LW    = 16;
    localparam int LN    = 4;
    localparam int AW    = 7;
    localparam int DEPTH = 128;
    localparam int DW    = LW * LN;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          sram_cen_n;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_data_in;
    logic          busy;
    logic          done;
    logic [AW:0]   words_written;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  done_cyc = -1;
    wr_t act_q[$];

    sram_input_loader_if #(.LANE_WIDTH(LW)) bus ();

    sram_input_loader #(
        .LANE_WIDTH(LW), .LANES(LN), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_words    (num_words),
        .s            (bus),
        .sram_cen_n   (sram_cen_n),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_data_in (sram_data_in),
        .busy         (busy),
        .done         (done),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Collect every SRAM write and done pulse as seen mid-cycle.
    always @(negedge clk) begin
        check("wen_vs_cen", {63'd0, sram_wen}, {63'd0, ~sram_cen_n});
        if (!sram_cen_n) act_q.push_back('{sram_addr, sram_data_in});
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "/cen_n"}, sram_cen_n, 1);
        check({tag, "/wen"},   sram_wen, 0);
        check({tag, "/addr"},  sram_addr, 0);
        check({tag, "/data"},  sram_data_in, 0);
        check({tag, "/ready"}, bus.ready, 0);
        check({tag, "/busy"},  busy, 0);
        check({tag, "/done"},  done, 0);
        check({tag, "/words"}, words_written, 0);
    endtask

    // One frame: build the element list, predict the line writes from the
    // packing rules, drive the stream, then compare everything observed.
    task automatic run_frame(input logic [AW-1:0] base, input logic [AW:0] nw,
                             input int n_elems, input int last_idx, input int gap_mode,
                             input bit mid_start, input bit seq, input string tag);
        logic [LW-1:0] elems[$];
        wr_t           exp_q[$];
        logic [DW-1:0] line;
        logic          rdy_after;
        int            cap, acc, nl, i, t, hs_cyc, budget;
        bit            hs, fired, v;

        for (int e = 0; e < n_elems; e++) elems.push_back(seq ? LW'(e + 1) : LW'($urandom));
        cap = ((int'(nw) > DEPTH) ? DEPTH : int'(nw)) * LN;
        acc = n_elems;
        if (last_idx >= 0 && last_idx + 1 < acc) acc = last_idx + 1;
        if (acc > cap) acc = cap;
        nl = (acc + LN - 1) / LN;
        for (int j = 0; j < nl; j++) begin
            line = '0;
            for (int l = 0; l < LN; l++)
                if (j * LN + l < acc) line[l*LW +: LW] = elems[j*LN + l];
            exp_q.push_back('{AW'((int'(base) + j) % DEPTH), line});
        end

        act_q.delete();
        done_cnt  = 0;
        start     = 1'b1;
        base_addr = base;
        num_words = nw;
        @(posedge clk); #1;
        start = 1'b0;

        i = 0; t = 0; hs_cyc = -1; fired = 0; rdy_after = 1'bx;
        budget = 4 * n_elems + 100;
        while (done_cnt == 0 && t < budget) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (t % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.valid = v && (i < n_elems);
            bus.data  = (i < n_elems) ? elems[i] : '0;
            bus.last  = (i == last_idx);
            if (mid_start && !fired && i == 3) begin
                start = 1'b1; base_addr = AW'(99); num_words = 1; fired = 1;
            end
            @(negedge clk);
            if (t == 0) check({tag, "/busy_fill"}, busy, 1);
            if (hs_cyc >= 0 && cyc == hs_cyc + 1) rdy_after = bus.ready;
            hs = bus.valid && bus.ready;
            if (hs && i == acc - 1) hs_cyc = cyc;
            @(posedge clk); #1;
            start = 1'b0;
            if (hs) i++;
            t++;
        end
        bus.valid = 1'b0;
        bus.last  = 1'b0;
        @(negedge clk);
        @(negedge clk);

        check({tag, "/done_once"}, done_cnt, 1);
        check({tag, "/busy_idle"}, busy, 0);
        check({tag, "/accepted"}, i, acc);
        check({tag, "/done_lat"}, done_cyc - hs_cyc, 2);
        check({tag, "/ready_drop"}, rdy_after, 0);
        check({tag, "/n_writes"}, act_q.size(), nl);
        for (int j = 0; j < nl && j < act_q.size(); j++) begin
            check($sformatf("%s/addr%0d", tag, j), act_q[j].addr, exp_q[j].addr);
            check($sformatf("%s/data%0d", tag, j), act_q[j].data, exp_q[j].data);
        end
        check({tag, "/words"}, words_written, nl);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, ne, li, mode;

        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
        bus.valid = 1'b0; bus.data = '0; bus.last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        @(posedge clk); #1;
        run_frame(7'd0,   8'd2, 8, -1, 0, 1'b0, 1'b1, "full");
        run_frame(7'd10,  8'd4, 6,  5, 0, 1'b0, 1'b1, "early_last");
        run_frame(7'd127, 8'd2, 8, -1, 0, 1'b0, 1'b1, "wrap");
        run_frame(7'd0,   8'd2, 8, -1, 1, 1'b1, 1'b1, "gaps");
        run_frame(7'd3,   8'd200, 516, -1, 0, 1'b0, 1'b0, "clamp");

        // Zero-length frame: immediate done, no activity.
        act_q.delete();
        done_cnt  = 0;
        start     = 1'b1;
        num_words = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zero/done", done, 1);
        check("zero/busy", busy, 0);
        @(negedge clk);
        check("zero/done_off", done, 0);
        check("zero/n_writes", act_q.size(), 0);
        @(posedge clk); #1;

        // Reset after 2 of 4 elements: partial line must be dropped.
        act_q.delete();
        start = 1'b1; base_addr = 7'd20; num_words = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.valid = 1'b1; bus.data = 16'h0011;
        @(posedge clk); #1;
        bus.data = 16'h0022;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        check("rst_mid/n_writes", act_q.size(), 0);
        @(posedge clk); #1;
        run_frame(7'd5, 8'd1, 4, -1, 0, 1'b0, 1'b0, "after_rst");

        for (int k = 0; k < 20; k++) begin
            nw   = $urandom_range(1, 5);
            mode = $urandom_range(0, 2);
            case (mode)
                0: begin ne = nw * LN + $urandom_range(0, 3); li = -1; end
                1: begin li = $urandom_range(0, nw * LN - 1); ne = li + 1 + $urandom_range(0, 2); end
                default: begin ne = nw * LN + 2; li = nw * LN + 1; end
            endcase
            run_frame(AW'($urandom_range(0, DEPTH - 1)), (AW + 1)'(nw), ne, li,
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0,
                      $sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
